// File: rtl/sisc_pkg.sv
// SISC shared definitions: opcodes, sequencer states,
// instruction field positions and status bit indices.
package sisc_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_RR = 4'h1;
  localparam logic [3:0] OP_ALU_RI = 4'h2;
  localparam logic [3:0] OP_BRA    = 4'h4;
  localparam logic [3:0] OP_BRR    = 4'h5;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam int OPC_LSB = 28;
  localparam int MM_LSB  = 24;
  localparam int RA_LSB  = 20;
  localparam int RB_LSB  = 16;
  localparam int RD_LSB  = 12;
  localparam int IMM_LSB = 0;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_V = 2;
  localparam int STAT_C = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    unique case (op)
      OP_NOP, OP_ALU_RR, OP_ALU_RI,
      OP_BRA, OP_BRR, OP_HALT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sisc_br_calc.sv
// Branch resolution: pc, imm, opcode, mm, stat -> taken, target.
// pc is the already-incremented PC; target wraps mod 2^ADDR_W.
module sisc_br_calc
  import sisc_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic [3:0]        opcode,
  input  logic [3:0]        mm,
  input  logic [3:0]        stat,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);

  logic cond;

  // mm of zero means unconditional
  assign cond = (mm == 4'h0) || ((mm & stat) != 4'h0);

  always_comb begin
    taken  = 1'b0;
    target = pc;
    unique case (opcode)
      OP_BRA: begin
        taken  = cond;
        target = ADDR_W'(imm);
      end
      OP_BRR: begin
        taken  = cond;
        target = pc + ADDR_W'(signed'(imm));
      end
      default: begin
        taken  = 1'b0;
        target = pc;
      end
    endcase
  end

endmodule

// File: rtl/sisc_seq.sv
// SISC multi-cycle sequencer: owns PC, IR, branch redirect,
// retired count; fetches over imem req/rdy, drives datapath strobes.
module sisc_seq
  import sisc_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] RST_VEC = '0,
  parameter int                CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [DATA_W-1:0] imem_data,
  input  logic [3:0]        stat,
  output logic [DATA_W-1:0] ir,
  output logic [1:0]        alu_op,
  output logic              alu_src,
  output logic              rd_sel,
  output logic              wb_sel,
  output logic              stat_en,
  output logic              rf_we,
  output logic              br_taken,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instret,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  logic [3:0]        opc;
  logic [3:0]        mm;
  logic [15:0]       imm;
  logic              is_alu;
  logic              taken;
  logic [ADDR_W-1:0] target;

  assign opc    = ir[OPC_LSB +: 4];
  assign mm     = ir[MM_LSB +: 4];
  assign imm    = ir[IMM_LSB +: 16];
  assign is_alu = (opc == OP_ALU_RR) || (opc == OP_ALU_RI);

  sisc_br_calc #(
    .ADDR_W(ADDR_W)
  ) u_br (
    .pc    (pc),
    .imm   (imm),
    .opcode(opc),
    .mm    (mm),
    .stat  (stat),
    .taken (taken),
    .target(target)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      pc      <= RST_VEC;
      ir      <= '0;
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_rdy) begin
            ir    <= imem_data;
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opc == OP_HALT) begin
            state   <= S_HALT;
            instret <= instret + CNT_W'(1);
          end else begin
            state <= S_EXEC;
            if (!op_legal(opc)) illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_alu) begin
            state <= S_WB;
          end else begin
            if (taken) pc <= target;
            instret <= instret + CNT_W'(1);
            state   <= S_FETCH;
          end
        end
        S_WB: begin
          instret <= instret + CNT_W'(1);
          state   <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign alu_op    = ir[MM_LSB +: 2];
  assign alu_src   = (opc == OP_ALU_RI);
  assign rd_sel    = (opc == OP_ALU_RR);
  assign halted    = (state == S_HALT);

  always_comb begin
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    br_taken = 1'b0;
    unique case (1'b1)
      (state == S_EXEC): begin
        stat_en  = is_alu;
        br_taken = taken;
      end
      (state == S_WB): begin
        rf_we  = 1'b1;
        wb_sel = 1'b1;
      end
      default: begin
        stat_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sisc_seq.sv
// Bench for sisc_seq (ADDR_W=8, CNT_W=8): directed programs plus
// random programs checked against an instruction-level model.
module tb_sisc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_data;
  logic [3:0]  stat;
  logic [31:0] ir;
  logic [1:0]  alu_op;
  logic        alu_src, rd_sel, wb_sel;
  logic        stat_en, rf_we, br_taken;
  logic [7:0]  pc;
  logic [7:0]  instret;
  logic        halted, illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  int          m_pc, m_instret;
  logic        m_illegal;
  logic [31:0] m_ir;

  always #5 clk = ~clk;

  sisc_seq #(
    .ADDR_W (8),
    .DATA_W (32),
    .RST_VEC(8'h00),
    .CNT_W  (8)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .imem_rdy (imem_rdy),
    .imem_data(imem_data),
    .stat     (stat),
    .ir       (ir),
    .alu_op   (alu_op),
    .alu_src  (alu_src),
    .rd_sel   (rd_sel),
    .wb_sel   (wb_sel),
    .stat_en  (stat_en),
    .rf_we    (rf_we),
    .br_taken (br_taken),
    .pc       (pc),
    .instret  (instret),
    .halted   (halted),
    .illegal  (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int mm,
                                     input int imm);
    return {op[3:0], mm[3:0], 8'h00, imm[15:0]};
  endfunction

  function automatic bit legal(input int op);
    return op == 0 || op == 1 || op == 2 || op == 4 || op == 5 || op == 15;
  endfunction

  // Hold reset for n cycles (optionally with a stray rdy), check the
  // reset image, then release and land in the first FETCH cycle.
  task automatic reset_dut(input bit late_rdy, input int n);
    rst = 1'b1;
    imem_rdy = late_rdy;
    imem_data = $urandom;
    repeat (n) @(negedge clk);
    imem_rdy = 1'b0;
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_stat_en", stat_en, 0);
    chk("rst_br", br_taken, 0);
    m_pc = 0;
    m_instret = 0;
    m_illegal = 1'b0;
    m_ir = 32'h0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Execute one instruction from FETCH. rst_mode: 0 none,
  // 1 reset on last fetch wait cycle (with late rdy), 2 reset in WB.
  task automatic run_instr(input int waits, input logic [3:0] st,
                           input int rst_mode);
    logic [31:0] ins;
    int opc, mm, imm, simm, npc;
    bit tk, alu;
    ins = mem[m_pc];
    for (int w = 0; w <= waits; w++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_ir_hold", ir, m_ir);
      chk("fetch_pc_hold", pc, m_pc);
      if (rst_mode == 1 && w == waits) begin
        imem_data = ins;
        reset_dut(1'b1, 1);
        return;
      end
      imem_rdy = (w == waits);
      imem_data = (w == waits) ? ins : $urandom;
      @(negedge clk);
    end
    imem_rdy = 1'b0;
    imem_data = $urandom;
    m_ir = ins;
    npc = (m_pc + 1) % 256;
    chk("dec_ir", ir, ins);
    chk("dec_pc", pc, npc);
    chk("dec_req", imem_req, 0);
    opc = int'(ins >> 28) & 15;
    mm = int'(ins >> 24) & 15;
    imm = int'(ins) & 16'hFFFF;
    stat = st;
    @(negedge clk);
    if (opc == 15) begin
      m_instret = (m_instret + 1) % 256;
      m_pc = npc;
      chk("halt_halted", halted, 1);
      chk("halt_instret", instret, m_instret);
      chk("halt_pc", pc, m_pc);
      chk("halt_req", imem_req, 0);
      return;
    end
    alu = (opc == 1 || opc == 2);
    tk = (opc == 4 || opc == 5) && (mm == 0 || (mm & int'(st)) != 0);
    if (!legal(opc)) m_illegal = 1'b1;
    chk("ex_stat_en", stat_en, alu);
    chk("ex_br_taken", br_taken, tk);
    chk("ex_rf_we", rf_we, 0);
    chk("ex_illegal", illegal, m_illegal);
    if (tk) begin
      simm = (imm >= 32768) ? imm - 65536 : imm;
      if (opc == 4) npc = imm % 256;
      else npc = ((npc + simm) % 256 + 256) % 256;
    end
    @(negedge clk);
    if (alu) begin
      chk("wb_rf_we", rf_we, 1);
      chk("wb_sel", wb_sel, 1);
      chk("wb_stat_en", stat_en, 0);
      chk("wb_rd_sel", rd_sel, opc == 1);
      chk("wb_alu_src", alu_src, opc == 2);
      chk("wb_alu_op", alu_op, mm & 3);
      if (rst_mode == 2) begin
        reset_dut(1'b0, 1);
        return;
      end
      @(negedge clk);
    end
    m_instret = (m_instret + 1) % 256;
    m_pc = npc;
    chk("ret_pc", pc, m_pc);
    chk("ret_instret", instret, m_instret);
    chk("ret_illegal", illegal, m_illegal);
    chk("ret_rf_we", rf_we, 0);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic check_parked(input int n);
    for (int i = 0; i < n; i++) begin
      chk("halt_no_req", imem_req, 0);
      chk("halt_stays", halted, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    int r, op;
    rst = 1'b1;
    imem_rdy = 1'b0;
    imem_data = 32'h0;
    stat = 4'h0;

    // NOP, NOP, HALT with zero wait states
    clear_mem();
    mem[2] = mk(15, 0, 0);
    reset_dut(1'b0, 2);
    run_instr(0, 4'h0, 0);
    run_instr(0, 4'h0, 0);
    run_instr(0, 4'h0, 0);
    chk("t1_instret", instret, 3);
    chk("t1_pc", pc, 3);
    check_parked(5);

    // ALU reg-reg behind five fetch wait cycles
    clear_mem();
    mem[0] = 32'h1112_3000;
    mem[1] = mk(15, 0, 0);
    reset_dut(1'b0, 1);
    run_instr(5, 4'h0, 0);
    run_instr(0, 4'h0, 0);

    // reset in a fetch wait, then in WB
    clear_mem();
    mem[0] = 32'h0ABC_DEF0;
    mem[1] = mk(2, 1, 16'h0042);
    reset_dut(1'b0, 1);
    run_instr(0, 4'h0, 0);
    run_instr(2, 4'h0, 1);
    run_instr(0, 4'h0, 0);
    run_instr(1, 4'h0, 2);
    run_instr(0, 4'h0, 0);

    // branches, address wrap, truncation, illegal, halt
    clear_mem();
    mem[8'h00] = mk(4, 0, 5);
    mem[8'h05] = mk(5, 1, 16'hFFFE);
    mem[8'h06] = mk(4, 0, 5);
    mem[8'h04] = mk(4, 0, 16'h0040);
    mem[8'h40] = mk(4, 0, 16'h00F8);
    mem[8'hF8] = mk(5, 0, 16'h0010);
    mem[8'h09] = mk(4, 0, 16'h1234);
    mem[8'h34] = mk(7, 0, 0);
    mem[8'h35] = mk(2, 3, 16'h00AA);
    mem[8'h37] = mk(15, 0, 0);
    reset_dut(1'b0, 1);
    run_instr(0, 4'h0, 0);
    run_instr(0, 4'b0010, 0);
    chk("t3_not_taken_pc", pc, 6);
    run_instr(1, 4'h0, 0);
    run_instr(0, 4'b0001, 0);
    chk("t3_taken_pc", pc, 4);
    run_instr(0, 4'h0, 0);
    chk("t3_bra_pc", pc, 8'h40);
    run_instr(0, 4'h0, 0);
    run_instr(0, 4'h0, 0);
    chk("t3_wrap_pc", pc, 8'h09);
    run_instr(0, 4'h0, 0);
    chk("t3_trunc_pc", pc, 8'h34);
    run_instr(0, 4'h0, 0);
    chk("t3_illegal", illegal, 1);
    run_instr(0, 4'h0, 0);
    run_instr(2, 4'h0, 0);
    chk("t3_illegal_sticky", illegal, 1);
    run_instr(0, 4'h0, 0);
    check_parked(10);

    // random programs, random waits and status; instret wraps
    clear_mem();
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: op = 0;
        1, 2: op = 1;
        3, 4: op = 2;
        5, 6: op = 4;
        7, 8: op = 5;
        default: begin
          op = $urandom_range(6, 14);
        end
      endcase
      mem[i] = {op[3:0], 4'($urandom_range(0, 15)),
                8'($urandom), 16'($urandom)};
    end
    reset_dut(1'b0, 1);
    for (int k = 0; k < 300; k++) begin
      run_instr($urandom_range(0, 3), 4'($urandom_range(0, 15)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
